ldm_stm_seq: RTL and testbench
==============================

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Block-transfer sequencer: drives the register file's ports to move a register list to or from data memory, one register per cycle (ARM LDM/STM).

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 is_load  input  1  1 = LDM (mem -> reg), 0 = STM (reg -> mem).
REQ-006 up  input  1  1 = increment-after (IA), 0 = decrement-before (DB).
REQ-007 reg_list  input  16  bit i set = register i transfers.
REQ-008 base_addr  input  32  base byte address.
REQ-009 rf_read_addr  output  4  register-file read port address (STM).
REQ-010 rf_read_data  input  32  asynchronous read data for rf_read_addr.
REQ-011 rf_wr_en / rf_write_addr / rf_write_data  output  1/4/32  register-file write port (LDM).
REQ-012 mem_addr  output  32  data-memory byte address.
REQ-013 mem_wr_en / mem_wdata  output  1/32  data-memory write (STM).
REQ-014 mem_rdata  input  32  asynchronous memory read data for mem_addr.
REQ-015 busy  output  1  high in XFER and DONE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 wb_addr  output  32  base writeback value; valid while done=1.

Function
REQ-018 FSM states SHALL be IDLE, XFER and DONE.
REQ-019 IDLE: start=1 at posedge latches reg_list, is_load, up and the start address. Next state is XFER if reg_list!=0, else DONE.
REQ-020 Start address SHALL be base_addr for IA and base_addr - 4*N for DB, where N = popcount(reg_list). All address arithmetic SHALL be modulo 2^32.
REQ-021 Each XFER cycle SHALL service idx = lowest set bit of the remaining list. Registers are therefore transferred in ascending order, lowest register at lowest address, for both IA and DB.
REQ-022 STM XFER cycle: rf_read_addr=idx, mem_addr=cur_addr, mem_wdata=rf_read_data, mem_wr_en=1, rf_wr_en=0.
REQ-023 LDM XFER cycle: mem_addr=cur_addr, rf_write_addr=idx, rf_write_data=mem_rdata, rf_wr_en=1, mem_wr_en=0.
REQ-024 At each XFER posedge, bit idx SHALL be cleared and cur_addr += 4. If the list becomes empty, the next state SHALL be DONE.
REQ-025 DONE SHALL last exactly one cycle: done=1, wb_addr = base+4N (IA) or base-4N (DB), write enables 0. Next state is IDLE.
REQ-026 Latency: start sampled at edge k gives XFER during cycles k+1..k+N and done in cycle k+N+1. An empty list gives done in cycle k+1.
REQ-027 start while busy=1 SHALL be ignored. Input changes after the latch SHALL not affect the transfer in progress.
REQ-028 Outside XFER, rf_wr_en, mem_wr_en, rf_read_addr, rf_write_addr, rf_write_data, mem_addr and mem_wdata SHALL be 0.
REQ-029 Outside DONE, wb_addr SHALL be 0.
REQ-030 Exactly one of rf_wr_en / mem_wr_en SHALL be high in any XFER cycle, and neither SHALL be high in any other state.

Reset
REQ-031 reset_n=0 SHALL immediately, without waiting for clk, force state IDLE, clear the latched list and address, and drive every output to 0.
REQ-032 Reset mid-transfer SHALL abort with no further writes. Registers already written keep their values.
REQ-033 After reset_n rises, the first start sampled SHALL begin a fresh transfer.

Verification
REQ-034 STM IA, reg_list=0x0013, base=0x100, r0/r1/r4=A/B/C -> mem[0x100]=A, mem[0x104]=B, mem[0x108]=C; done 4 cycles after start; wb_addr=0x10C.
REQ-035 LDM DB, reg_list=0x8001, base=0x200, mem[0x1F8]=X, mem[0x1FC]=Y -> r0=X, r15=Y; wb_addr=0x1F8; rf_wr_en high exactly 2 cycles.
REQ-036 reg_list=0x0000, base=0x40 -> no write enable ever high; done in the cycle after start; wb_addr=0x40.
REQ-037 STM IA, reg_list=0xFFFF, base=0xFFFFFFF0 -> 16 writes at 0xFFFFFFF0..0x0000002C (wrapping); wb_addr=0x00000030; done 17 cycles after start.
REQ-038 Pulse start again during an LDM of 0x00F0 -> ignored, exactly 4 rf writes occur.
REQ-039 Assert reset_n=0 in the 2nd XFER cycle of STM 0x000F -> outputs 0 asynchronously; only mem at base written; next start runs a full transfer.

Source files
------------

// File: rtl/ldm_stm_seq.sv
// Block-transfer sequencer for ARM-style LDM/STM: moves one register per cycle between the
// register file and data memory, lowest register at lowest address.
module ldm_stm_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic [15:0] reg_list,
  input  logic [31:0] base_addr,
  output logic [3:0]  rf_read_addr,
  input  logic [31:0] rf_read_data,
  output logic        rf_wr_en,
  output logic [3:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] wb_addr
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic        load_q, load_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_q, wb_d;

  logic [4:0]  n_regs;
  logic [31:0] span;
  logic [3:0]  idx;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  assign n_regs = popcount16(reg_list);
  assign span   = {25'd0, n_regs, 2'b00};

  // Descending scan so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) idx = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      list_q  <= '0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    load_d  = load_q;
    addr_d  = addr_q;
    wb_d    = wb_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          list_d  = reg_list;
          load_d  = is_load;
          // DB starts below the base so the lowest register still lands lowest.
          addr_d  = up ? base_addr : base_addr - span;
          wb_d    = up ? base_addr + span : base_addr - span;
          state_d = (reg_list == 16'd0) ? StDone : StXfer;
        end
      end
      StXfer: begin
        list_d = list_q & (list_q - 16'd1);
        addr_d = addr_q + 32'd4;
        if (list_d == 16'd0) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rf_read_addr  = '0;
    rf_wr_en      = 1'b0;
    rf_write_addr = '0;
    rf_write_data = '0;
    mem_addr      = '0;
    mem_wr_en     = 1'b0;
    mem_wdata     = '0;
    busy          = 1'b0;
    done          = 1'b0;
    wb_addr       = '0;
    unique case (state_q)
      StXfer: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (load_q) begin
          rf_wr_en      = 1'b1;
          rf_write_addr = idx;
          rf_write_data = mem_rdata;
        end else begin
          rf_read_addr = idx;
          mem_wr_en    = 1'b1;
          mem_wdata    = rf_read_data;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        wb_addr = wb_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: the driver queues expected writes/completions, the monitor
// pops and compares them whenever the sequencer presents a write or done.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        is_load;
  logic        up;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        rf_wr_en;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] wb_addr;

  always #5 clk = ~clk;

  ldm_stm_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .is_load      (is_load),
    .up           (up),
    .reg_list     (reg_list),
    .base_addr    (base_addr),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .rf_wr_en     (rf_wr_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .wb_addr      (wb_addr)
  );

  logic [31:0] rf_m  [16];
  logic [31:0] mem_m [256];

  assign rf_read_data = rf_m[rf_read_addr];
  assign mem_rdata    = mem_m[mem_addr[9:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;  // 0 mem write, 1 rf write, 2 done
    logic [31:0] addr;
    logic [3:0]  ridx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int rf_wr_cnt = 0;
  int mem_wr_cnt = 0;

  localparam logic [31:0] ValA = 32'hAAAA_0000;
  localparam logic [31:0] ValB = 32'hBBBB_1111;
  localparam logic [31:0] ValC = 32'hCCCC_4444;
  localparam logic [31:0] ValX = 32'h1234_5678;
  localparam logic [31:0] ValY = 32'h9ABC_DEF0;
  localparam logic [31:0] Sentinel = 32'h5E5E_5E5E;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("we_exclusive", {31'd0, mem_wr_en & rf_wr_en}, 32'd0);
        if (!done) check("wb_idle", wb_addr, 32'd0);
        if (!mem_wr_en && !rf_wr_en)
          check("bus_idle", mem_addr | mem_wdata | rf_write_data |
                {28'd0, rf_read_addr} | {28'd0, rf_write_addr}, 32'd0);
        if (mem_wr_en || rf_wr_en || done) begin
          check("busy", {31'd0, busy}, 32'd1);
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got we=%0b/%0b done=%0b expected nothing", mem_wr_en,
                     rf_wr_en, done);
          end else begin
            e = sb.pop_front();
            k = done ? 2 : (rf_wr_en ? 1 : 0);
            check("kind", 32'(k), 32'(e.kind));
            check("cycle", 32'(cyc), 32'(e.cyc));
            if (done) begin
              check("wb_addr", wb_addr, e.addr);
            end else if (rf_wr_en) begin
              check("ld_mem_addr", mem_addr, e.addr);
              check("rf_write_addr", {28'd0, rf_write_addr}, {28'd0, e.ridx});
              check("rf_write_data", rf_write_data, e.data);
            end else begin
              check("st_mem_addr", mem_addr, e.addr);
              check("rf_read_addr", {28'd0, rf_read_addr}, {28'd0, e.ridx});
              check("mem_wdata", mem_wdata, e.data);
            end
          end
          if (mem_wr_en) begin
            mem_m[mem_addr[9:2]] = mem_wdata;
            mem_wr_cnt++;
          end
          if (rf_wr_en) begin
            rf_m[rf_write_addr] = rf_write_data;
            rf_wr_cnt++;
          end
        end
      end
    end
  end

  // Issue one transfer; returns just after the start edge. Without full, only the first
  // transfer is expected (used when the run is cut short by reset).
  task automatic run(input logic ld, input logic u, input logic [15:0] lst,
                     input logic [31:0] base, input bit full);
    exp_t        e;
    int          s;
    int          n;
    int          j;
    logic [31:0] a;
    @(negedge clk);
    is_load   = ld;
    up        = u;
    reg_list  = lst;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start     = 1'b0;
    is_load   = ~ld;
    up        = ~u;
    reg_list  = 16'h5A5A;
    base_addr = 32'hDEAD_0000;
    n = $countones(lst);
    a = u ? base : base - 32'(4 * n);
    j = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i] && (full || j == 0)) begin
        e.kind = ld ? 1 : 0;
        e.addr = a;
        e.ridx = 4'(i);
        e.data = ld ? mem_m[a[9:2]] : rf_m[i];
        e.cyc  = s + j;
        sb.push_back(e);
        a = a + 32'd4;
        j++;
      end
    end
    if (full) begin
      e.kind = 2;
      e.addr = u ? base + 32'(4 * n) : base - 32'(4 * n);
      e.ridx = '0;
      e.data = '0;
      e.cyc  = s + n;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: got %0d pending expectations expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, mem_addr | mem_wdata | rf_write_data | wb_addr |
          {16'd0, rf_read_addr, rf_write_addr, 4'd0, rf_wr_en, mem_wr_en, busy, done}, 32'd0);
  endtask

  initial begin
    int c_rf;
    int c_mem;
    reset_n   = 1'b0;
    start     = 1'b0;
    is_load   = 1'b0;
    up        = 1'b0;
    reg_list  = '0;
    base_addr = '0;
    for (int i = 0; i < 16; i++) rf_m[i] = 32'h5000_0000 | 32'(i);
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    rf_m[0] = ValA;
    rf_m[1] = ValB;
    rf_m[4] = ValC;
    mem_m[8'h7E] = ValX;  // 0x1F8
    mem_m[8'h7F] = ValY;  // 0x1FC
    for (int i = 0; i < 4; i++) mem_m[32 + i] = 32'h7700_0000 + 32'(i);  // 0x80..0x8C
    mem_m[8'hC1] = Sentinel;  // 0x304

    #12;
    check_all_zero("reset_outputs");
    reset_n = 1'b1;

    // STM IA, r0/r1/r4 -> 0x100..0x108
    run(1'b0, 1'b1, 16'h0013, 32'h0000_0100, 1'b1);
    wait_drain();
    check("stm_ia_mem100", mem_m[64], ValA);
    check("stm_ia_mem104", mem_m[65], ValB);
    check("stm_ia_mem108", mem_m[66], ValC);

    // LDM DB r0,r15 from 0x1F8
    c_rf = rf_wr_cnt;
    run(1'b1, 1'b0, 16'h8001, 32'h0000_0200, 1'b1);
    wait_drain();
    check("ldm_db_r0", rf_m[0], ValX);
    check("ldm_db_r15", rf_m[15], ValY);
    check("ldm_db_rf_writes", 32'(rf_wr_cnt - c_rf), 32'd2);

    // Empty list
    c_rf  = rf_wr_cnt;
    c_mem = mem_wr_cnt;
    run(1'b0, 1'b1, 16'h0000, 32'h0000_0040, 1'b1);
    wait_drain();
    check("empty_writes", 32'(rf_wr_cnt - c_rf + mem_wr_cnt - c_mem), 32'd0);

    // STM IA full list, wrapping address space
    run(1'b0, 1'b1, 16'hFFFF, 32'hFFFF_FFF0, 1'b1);
    wait_drain();
    check("wrap_first", mem_m[8'hFC], ValX);
    check("wrap_last", mem_m[8'h0B], ValY);

    // LDM with a start pulse while busy
    c_rf  = rf_wr_cnt;
    c_mem = mem_wr_cnt;
    run(1'b1, 1'b1, 16'h00F0, 32'h0000_0080, 1'b1);
    @(negedge clk);
    is_load  = 1'b0;
    reg_list = 16'hFFFF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    check("busy_start_rf_writes", 32'(rf_wr_cnt - c_rf), 32'd4);
    check("busy_start_mem_writes", 32'(mem_wr_cnt - c_mem), 32'd0);
    check("ldm_r7", rf_m[7], 32'h7700_0003);

    // Reset in the second XFER cycle of STM 0x000F
    c_mem = mem_wr_cnt;
    run(1'b0, 1'b1, 16'h000F, 32'h0000_0300, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    check("abort_pending", 32'(sb.size()), 32'd0);
    check("abort_mem_writes", 32'(mem_wr_cnt - c_mem), 32'd1);
    check("abort_mem300", mem_m[8'hC0], rf_m[0]);
    check("abort_mem304", mem_m[8'hC1], Sentinel);
    run(1'b0, 1'b1, 16'h000F, 32'h0000_0300, 1'b1);
    wait_drain();
    check("rerun_mem304", mem_m[8'hC1], rf_m[1]);
    check("rerun_mem30c", mem_m[8'hC3], rf_m[3]);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
